// File: rtl/cam_rule_writer_pkg.sv
// Shared types for the CAM rule writer: request opcodes, response codes and FSM states.
package cam_pkg;

    typedef enum logic {
        OP_INSERT = 1'b0,
        OP_DELETE = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_OK     = 2'b00,
        ST_MISS   = 2'b01,
        ST_SHADOW = 2'b10,
        ST_STALE  = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_GAP   = 3'd2,
        S_PROBE = 3'd3,
        S_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/cam_rule_writer_if.sv
// Rule request/response port between the control-plane rule manager (master) and the writer (slave).
interface cam_rule_writer_if #(
    parameter int AW     = 6,
    parameter int WIDTH  = 36,
    parameter int KBIT_W = 16
);
    logic              reqValid;
    logic              reqReady;
    logic              reqOp;
    logic [AW-1:0]     reqAddr;
    logic [WIDTH-1:0]  reqPatt;
    logic [WIDTH-1:0]  reqMask;
    logic [KBIT_W-1:0] reqKbit;
    logic              rspValid;
    logic              rspReady;
    logic [1:0]        rspStatus;
    logic [AW-1:0]     rspAddr;

    modport master (
        output reqValid, reqOp, reqAddr, reqPatt, reqMask, reqKbit, rspReady,
        input  reqReady, rspValid, rspStatus, rspAddr
    );

    modport slave (
        input  reqValid, reqOp, reqAddr, reqPatt, reqMask, reqKbit, rspReady,
        output reqReady, rspValid, rspStatus, rspAddr
    );
endinterface

// File: rtl/cam_rule_writer.sv
// Sole writer of fpga_cam: holds the write port stable for the update window, optionally
// probes the match port to confirm the rule, then returns a status response.
//   state   | meaning
//   IDLE    | waiting for a request, reqReady high
//   WRITE   | wEn high, write fields stable, UPD_CYCLES long
//   GAP     | one cycle with wEn low before probing
//   PROBE   | mPatt driven, MATCH_LAT cycles until match/mAddr are sampled
//   RESP    | response held until rspReady
module cam_rule_writer
    import cam_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int WIDTH      = 36,
    parameter int KBIT_W     = 16,
    parameter int UPD_CYCLES = 64,
    parameter int MATCH_LAT  = 2,
    parameter int VERIFY     = 1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    cam_rule_writer_if.slave   rif,
    output logic               busy,
    output logic               wEn,
    output logic [AW-1:0]      wAddr,
    output logic [WIDTH-1:0]   wPatt,
    output logic [WIDTH-1:0]   wMask,
    output logic [KBIT_W-1:0]  wKbit,
    output logic [WIDTH-1:0]   mPatt,
    input  logic               match,
    input  logic [AW-1:0]      mAddr
);
    localparam int CW = $clog2(UPD_CYCLES + 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    op_e               op_q, op_d;
    logic              wen_q, wen_d;
    logic [AW-1:0]     waddr_q, waddr_d;
    logic [WIDTH-1:0]  wpatt_q, wpatt_d;
    logic [WIDTH-1:0]  wmask_q, wmask_d;
    logic [KBIT_W-1:0] wkbit_q, wkbit_d;
    logic [WIDTH-1:0]  mpatt_q, mpatt_d;
    logic              rsp_valid_q, rsp_valid_d;
    status_e           rsp_status_q, rsp_status_d;
    logic [AW-1:0]     rsp_addr_q, rsp_addr_d;
    status_e           probe_status;
    logic              hit_self;

    always_comb begin
        hit_self = match && (mAddr == waddr_q);
        if (op_q == OP_INSERT)
            probe_status = hit_self ? ST_OK : (match ? ST_SHADOW : ST_MISS);
        else
            probe_status = hit_self ? ST_STALE : ST_OK;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        wen_d        = 1'b0;
        waddr_d      = waddr_q;
        wpatt_d      = wpatt_q;
        wmask_d      = wmask_q;
        wkbit_d      = wkbit_q;
        mpatt_d      = mpatt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_status_d = rsp_status_q;
        rsp_addr_d   = rsp_addr_q;
        case (state_q)
            S_IDLE: begin
                if (rif.reqValid) begin
                    state_d = S_WRITE;
                    cnt_d   = CW'(UPD_CYCLES - 1);
                    op_d    = op_e'(rif.reqOp);
                    wen_d   = 1'b1;
                    waddr_d = rif.reqAddr;
                    wpatt_d = rif.reqPatt;
                    wmask_d = rif.reqMask;
                    wkbit_d = (rif.reqOp == OP_DELETE) ? '0 : rif.reqKbit;
                end
            end
            S_WRITE: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    wen_d = 1'b1;
                end
            end
            S_GAP: begin
                if (VERIFY != 0) begin
                    state_d = S_PROBE;
                    cnt_d   = CW'(MATCH_LAT - 1);
                    mpatt_d = wpatt_q & ~wmask_q;
                end else begin
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = ST_OK;
                    rsp_addr_d   = waddr_q;
                end
            end
            S_PROBE: begin
                if (cnt_q == '0) begin
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = probe_status;
                    rsp_addr_d   = (op_q == OP_INSERT) ? mAddr : waddr_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                if (rif.rspReady) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            op_q         <= OP_INSERT;
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            wpatt_q      <= '0;
            wmask_q      <= '0;
            wkbit_q      <= '0;
            mpatt_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= ST_OK;
            rsp_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            wen_q        <= wen_d;
            waddr_q      <= waddr_d;
            wpatt_q      <= wpatt_d;
            wmask_q      <= wmask_d;
            wkbit_q      <= wkbit_d;
            mpatt_q      <= mpatt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            rsp_addr_q   <= rsp_addr_d;
        end
    end

    assign rif.reqReady  = (state_q == S_IDLE);
    assign rif.rspValid  = rsp_valid_q;
    assign rif.rspStatus = rsp_status_q;
    assign rif.rspAddr   = rsp_addr_q;
    assign busy          = (state_q != S_IDLE);
    assign wEn           = wen_q;
    assign wAddr         = waddr_q;
    assign wPatt         = wpatt_q;
    assign wMask         = wmask_q;
    assign wKbit         = wkbit_q;
    assign mPatt         = mpatt_q;

endmodule

// File: doc/cam_rule_writer.md
Name: cam_rule_writer

Overview:
- Update initiator for fpga_cam. Accepts rule insert/delete requests on a valid/ready port and drives the CAM write port (wEn/wAddr/wPatt/wMask/wKbit) stably for the full multi-cycle update window.
- Optionally probes the CAM match port afterwards to confirm the rule landed, then returns a status response.
- Sits between the control-plane rule manager and fpga_cam. It is the only writer of the CAM.

Parameters:
- DEPTH, 64, CAM entries; address width AW = $clog2(DEPTH).
- WIDTH, 36, pattern/mask width.
- KBIT_W, 16, width of the wKbit field.
- UPD_CYCLES, 64, cycles wEn must be held high with all write fields stable.
- MATCH_LAT, 2, cycles from mPatt change to valid match/mAddr.
- VERIFY, 1, 1 = probe after write; 0 = respond OK without probing.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- reqValid  in  1  request valid
- reqReady  out  1  request accepted when reqValid && reqReady
- reqOp  in  1  0 = insert, 1 = delete
- reqAddr  in  AW  target entry
- reqPatt  in  WIDTH  pattern
- reqMask  in  WIDTH  1 = don't-care bit
- reqKbit  in  KBIT_W  kbit field (insert only)
- rspValid  out  1  response valid
- rspReady  in  1  response consumed
- rspStatus  out  2  result code
- rspAddr  out  AW  insert: mAddr seen at probe; delete: reqAddr
- busy  out  1  high whenever state != IDLE
- wEn  out  1  CAM write enable
- wAddr  out  AW  CAM write address
- wPatt  out  WIDTH  CAM write pattern
- wMask  out  WIDTH  CAM write mask
- wKbit  out  KBIT_W  CAM write kbit
- mPatt  out  WIDTH  CAM lookup pattern
- match  in  1  CAM match flag
- mAddr  in  AW  CAM matching address

Behaviour:
- Reset (async assert, sync release): state IDLE. wEn=0; wAddr/wPatt/wMask/wKbit/mPatt=0; rspValid=0, rspStatus=0, rspAddr=0, busy=0. All registered outputs.
- States: IDLE -> WRITE -> GAP -> PROBE -> RESP -> IDLE. PROBE is skipped when VERIFY=0.
- IDLE:
  - reqReady=1 (combinational, state==IDLE).
  - On handshake, capture all request fields; next cycle enter WRITE.
- WRITE:
  - wEn=1 for exactly UPD_CYCLES consecutive cycles. Counter width $clog2(UPD_CYCLES+1).
  - wAddr=addr, wPatt=patt, wMask=mask.
  - wKbit=kbit for insert; all zeros for delete.
  - All write fields stable for the whole window.
- GAP:
  - Exactly 1 cycle, wEn=0. Write fields keep their values; no clearing.
- PROBE:
  - mPatt = patt & ~mask, driven from the first PROBE cycle.
  - match/mAddr are sampled on the MATCH_LAT-th PROBE cycle, giving MATCH_LAT cycles in PROBE.
- Status computation:
  - Insert: OK if match && mAddr==addr; SHADOW if match && mAddr!=addr; MISS if !match.
  - Delete: OK if !match || mAddr!=addr; STALE if match && mAddr==addr.
- RESP:
  - rspValid=1; rspStatus and rspAddr held stable until rspReady.
  - On rspValid && rspReady, next state is IDLE. No new request is taken in the same cycle.
- VERIFY=0: RESP follows GAP directly, with status OK and rspAddr=addr.
- Throughput: one request in flight at a time. Minimum request-to-response latency is 1 + UPD_CYCLES + 1 + MATCH_LAT cycles.
- match/mAddr are ignored outside PROBE. mPatt holds its last value outside PROBE.
- Reset mid-operation:
  - wEn drops immediately (asynchronous). No response is issued.
  - CAM entry contents are undefined; the rule manager must re-issue the request.
- reqValid asserted during reset is ignored.
- The CAM lookup port is owned by this block. External lookups are not arbitrated here.

Decomposition:
- Package cam_pkg:
  - op_e {OP_INSERT=1'b0, OP_DELETE=1'b1}.
  - status_e {ST_OK=2'b00, ST_MISS=2'b01, ST_SHADOW=2'b10, ST_STALE=2'b11}.
  - state_e for the FSM.
- No sub-module. A single FSM plus one down-counter shared by WRITE and PROBE.

Test Plan:
- Basic insert: insert addr 0x10, patt 0x1234, mask 0, kbit 0x0001 against fpga_cam (DEPTH 64, WIDTH 36).
  - wEn high for exactly 64 cycles, fields stable throughout.
  - Then rspStatus=ST_OK, rspAddr=0x10.
- Shadowed insert: insert addr 0x05, patt 0x1230, mask 0xF, kbit 0x0001; then insert addr 0x10, patt 0x1234, mask 0.
  - Second response is ST_SHADOW with rspAddr=0x05.
- Delete: after the basic insert, delete addr 0x10.
  - wKbit=0 for the whole window.
  - Response ST_OK; a follow-up probe of 0x1234 gives match=0.
- Backpressure: hold rspReady=0 for 10 cycles after rspValid.
  - rspValid, rspStatus and rspAddr stay stable; reqReady stays 0.
  - A queued reqValid is accepted only the cycle after the response handshake.
- Reset mid-write: assert rst_n=0 at WRITE cycle 30.
  - wEn=0 within the same cycle; no rspValid.
  - reqReady=1 on the first cycle after release.
- VERIFY=0 build: basic insert responds ST_OK exactly 1+64+1 cycles after the accept, with mPatt unchanged.
